video_fb_arbiter: RTL and testbench

VIDEO_FB_ARBITER -- requirements
Module: video_fb_arbiter

---
 rtl/video_fb_arbiter.sv | 167 ++++++++++++++++
 tb/tb_video_fb_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_fb_arbiter.sv
// -----------------------------------------------------------------------------
// video_fb_arbiter
// Arbitrates a single burst memory port between the display line prefetcher
// (reads) and the camera writer (writes). Display fetches always win. A burst
// that has been accepted always runs to mem_done.
//
// Ports
//   clk, rst        : clock; asynchronous active-low reset
//   H_count/V_count : raster position from the timing generator
//   cam_req/cam_addr: camera write-burst request (level) and start address
//   cam_gnt         : one-cycle pulse when the camera burst is accepted
//   cam_done        : one-cycle pulse when the camera burst completes
//   mem_req/mem_we  : memory burst request; 1 = write, 0 = read
//   mem_addr        : burst start address, stable until mem_ack
//   mem_ack/mem_done: memory accepted request / burst finished
//   lb_sel          : line-buffer half targeted by display reads
//   underrun        : sticky flag, a new line arrived before the last finished
// -----------------------------------------------------------------------------
module video_fb_arbiter #(
   parameter int H_ACTIVE    = 800,
   parameter int V_ACTIVE    = 600,
   parameter int ENDFRAME    = 627,
   parameter int FETCH_START = 800,
   parameter int BURST_LEN   = 16,
   parameter int ADDR_W      = 20
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [10:0]       H_count,
   input  logic [10:0]       V_count,
   input  logic              cam_req,
   input  logic [ADDR_W-1:0] cam_addr,
   output logic              cam_gnt,
   output logic              cam_done,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_ack,
   input  logic              mem_done,
   output logic              lb_sel,
   output logic              underrun
);

   localparam int                PEND_W          = $clog2(H_ACTIVE / BURST_LEN + 1);
   localparam logic [PEND_W-1:0] BURSTS_PER_LINE = PEND_W'(H_ACTIVE / BURST_LEN);
   localparam logic [ADDR_W-1:0] LINE_STRIDE     = ADDR_W'(H_ACTIVE);
   localparam logic [ADDR_W-1:0] BURST_STRIDE    = ADDR_W'(BURST_LEN);
   localparam logic [10:0]       FETCH_H         = 11'(FETCH_START);
   localparam logic [10:0]       V_LAST_FETCH    = 11'(V_ACTIVE - 1);
   localparam logic [10:0]       V_EOF           = 11'(ENDFRAME);

   typedef enum logic [2:0] {
      IDLE,
      DISP_REQ,
      DISP_BUSY,
      CAM_REQ,
      CAM_BUSY
   } state_t;

   state_t            state_q, state_d;
   logic [PEND_W-1:0] disp_pending_q, disp_pending_d;
   logic [ADDR_W-1:0] disp_addr_q, disp_addr_d;
   logic [ADDR_W-1:0] line_base_q, line_base_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic              lb_sel_q, lb_sel_d;
   logic              underrun_q, underrun_d;
   logic              reloaded_q, reloaded_d;
   logic              trigger;
   logic              trigger_eof;

   // Lines 0..V_ACTIVE-2 prefetch the following line; the last line of the
   // frame prefetches line 0 of the next frame.
   assign trigger_eof = (V_count == V_EOF);
   assign trigger     = (H_count == FETCH_H) && ((V_count < V_LAST_FETCH) || trigger_eof);

   always_comb begin
      state_d        = state_q;
      disp_pending_d = disp_pending_q;
      disp_addr_d    = disp_addr_q;
      line_base_d    = line_base_q;
      mem_addr_d     = mem_addr_q;
      lb_sel_d       = lb_sel_q;
      underrun_d     = underrun_q;
      reloaded_d     = reloaded_q;

      case (state_q)
         IDLE: begin
            // The request address is latched on entry so it cannot move
            // while the memory has not yet accepted it.
            if (disp_pending_q != '0) begin
               state_d    = DISP_REQ;
               mem_addr_d = disp_addr_q;
            end else if (cam_req) begin
               state_d    = CAM_REQ;
               mem_addr_d = cam_addr;
            end
         end
         DISP_REQ: begin
            if (mem_ack) state_d = DISP_BUSY;
         end
         DISP_BUSY: begin
            if (mem_done) begin
               state_d    = IDLE;
               reloaded_d = 1'b0;
               // A burst belonging to a line that has since been replaced
               // must not consume a slot of the new line.
               if (!trigger && !reloaded_q) begin
                  if (disp_pending_q != '0) disp_pending_d = disp_pending_q - PEND_W'(1);
                  disp_addr_d = disp_addr_q + BURST_STRIDE;
               end
            end
         end
         CAM_REQ: begin
            if (mem_ack) state_d = CAM_BUSY;
         end
         CAM_BUSY: begin
            if (mem_done) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      if (trigger) begin
         if (disp_pending_q != '0) underrun_d = 1'b1;
         disp_pending_d = BURSTS_PER_LINE;
         lb_sel_d       = ~lb_sel_q;
         if (trigger_eof) begin
            disp_addr_d = '0;
            line_base_d = LINE_STRIDE;
         end else begin
            disp_addr_d = line_base_q;
            line_base_d = line_base_q + LINE_STRIDE;
         end
         if ((state_q == DISP_REQ) || ((state_q == DISP_BUSY) && !mem_done)) reloaded_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         disp_pending_q <= '0;
         disp_addr_q    <= '0;
         line_base_q    <= '0;
         mem_addr_q     <= '0;
         lb_sel_q       <= 1'b0;
         underrun_q     <= 1'b0;
         reloaded_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         disp_pending_q <= disp_pending_d;
         disp_addr_q    <= disp_addr_d;
         line_base_q    <= line_base_d;
         mem_addr_q     <= mem_addr_d;
         lb_sel_q       <= lb_sel_d;
         underrun_q     <= underrun_d;
         reloaded_q     <= reloaded_d;
      end
   end

   assign mem_req  = (state_q == DISP_REQ) || (state_q == CAM_REQ);
   assign mem_we   = (state_q == CAM_REQ);
   assign mem_addr = mem_addr_q;
   assign cam_gnt  = (state_q == CAM_REQ) && mem_ack;
   assign cam_done = (state_q == CAM_BUSY) && mem_done;
   assign lb_sel   = lb_sel_q;
   assign underrun = underrun_q;

endmodule

// File: tb/tb_video_fb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_video_fb_arbiter
// Drives raster triggers, camera requests and a randomised memory responder.
// A transaction-level model (queue of expected display burst addresses, the
// expected camera address, line-base/lb_sel/underrun bookkeeping) is compared
// against the DUT every cycle; a few literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_video_fb_arbiter;

   localparam int H_ACTIVE    = 800;
   localparam int V_ACTIVE    = 600;
   localparam int ENDFRAME    = 627;
   localparam int FETCH_START = 800;
   localparam int BURST_LEN   = 16;
   localparam int ADDR_W      = 20;
   localparam int NBURST      = H_ACTIVE / BURST_LEN;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [10:0]       H_count = '0;
   logic [10:0]       V_count = '0;
   logic              cam_req = 1'b0;
   logic [ADDR_W-1:0] cam_addr = '0;
   logic              cam_gnt, cam_done, mem_req, mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_ack = 1'b0;
   logic              mem_done = 1'b0;
   logic              lb_sel, underrun;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   video_fb_arbiter #(
      .H_ACTIVE(H_ACTIVE), .V_ACTIVE(V_ACTIVE), .ENDFRAME(ENDFRAME),
      .FETCH_START(FETCH_START), .BURST_LEN(BURST_LEN), .ADDR_W(ADDR_W)
   ) dut (
      .clk(clk), .rst(rst), .H_count(H_count), .V_count(V_count),
      .cam_req(cam_req), .cam_addr(cam_addr), .cam_gnt(cam_gnt), .cam_done(cam_done),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_done(mem_done), .lb_sel(lb_sel), .underrun(underrun)
   );

   // model state
   logic [ADDR_W-1:0] disp_q[$];
   logic [ADDR_W-1:0] seen_q[$];
   logic [ADDR_W-1:0] m_base = '0;
   logic [ADDR_W-1:0] cam_exp = '0;
   logic [ADDR_W-1:0] cam_last = '0;
   logic [ADDR_W-1:0] prev_addr = '0;
   bit m_lb = 0, m_ur = 0;
   bit disp_busy = 0, disp_counts = 0, cam_busy = 0, trig_in_camreq = 0;
   bit prev_req = 0, prev_ack = 0, prev_we = 0, prev_done_burst = 0;
   int cam_done_cnt = 0, cam_gnt_cnt = 0, cam_mark = 0, disp_before_cam = 0;

   // responder state
   bit fast = 1, hold_done = 0, stray_en = 0, rsp_busy = 0;
   int rsp_wait = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic bit is_trig(input logic [10:0] h, input logic [10:0] v);
      return (int'(h) == FETCH_START) && ((int'(v) < V_ACTIVE - 1) || (int'(v) == ENDFRAME));
   endfunction

   task automatic monitor();
      logic [ADDR_W-1:0] start;
      if (!rst) begin
         chk("reset_ctrl_outs", {26'b0, mem_req, mem_we, cam_gnt, cam_done, lb_sel, underrun}, 32'h0);
         chk("reset_mem_addr", 32'(mem_addr), 32'h0);
         disp_q.delete();
         m_base = '0; m_lb = 0; m_ur = 0;
         disp_busy = 0; disp_counts = 0; cam_busy = 0; trig_in_camreq = 0;
         prev_req = 0; prev_ack = 0; prev_we = 0; prev_done_burst = 0;
         return;
      end
      chk("lb_sel", 32'(lb_sel), 32'(m_lb));
      chk("underrun", 32'(underrun), 32'(m_ur));
      chk("cam_gnt", 32'(cam_gnt), 32'(mem_req && mem_we && mem_ack));
      chk("cam_done", 32'(cam_done), 32'(mem_done && cam_busy));
      if (prev_done_burst) chk("arb_gap_req", 32'(mem_req), 32'h0);
      if (disp_busy || cam_busy) chk("no_preempt_req", 32'(mem_req), 32'h0);
      if (prev_req && !prev_ack) begin
         chk("req_held", 32'(mem_req), 32'h1);
         chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
         chk("we_stable", 32'(mem_we), 32'(prev_we));
      end
      if (mem_req && !mem_we) chk("read_has_pending", 32'(disp_q.size() != 0), 32'h1);
      if (mem_req && mem_ack) begin
         if (!mem_we) begin
            if (disp_q.size() > 0) begin
               chk("read_addr", 32'(mem_addr), 32'(disp_q[0]));
               seen_q.push_back(mem_addr);
               void'(disp_q.pop_front());
               disp_busy = 1; disp_counts = 1;
            end
         end else begin
            chk("write_addr", 32'(mem_addr), 32'(cam_exp));
            if (!trig_in_camreq) chk("display_priority", 32'(disp_q.size()), 32'h0);
            cam_last = mem_addr;
            disp_before_cam = seen_q.size();
            cam_busy = 1; cam_gnt_cnt++; trig_in_camreq = 0;
         end
      end
      prev_done_burst = mem_done && (disp_busy || cam_busy);
      if (is_trig(H_count, V_count)) begin
         if (cam_req && !(mem_req && mem_we && mem_ack)) trig_in_camreq = 1;
         if (disp_q.size() != 0 || (disp_busy && disp_counts)) m_ur = 1;
         disp_q.delete();
         if (int'(V_count) == ENDFRAME) begin
            start = '0; m_base = ADDR_W'(H_ACTIVE);
         end else begin
            start = m_base; m_base = m_base + ADDR_W'(H_ACTIVE);
         end
         for (int i = 0; i < NBURST; i++) disp_q.push_back(start + ADDR_W'(i * BURST_LEN));
         m_lb = !m_lb;
         disp_counts = 0;
      end
      if (mem_done) begin
         if (cam_busy) begin cam_busy = 0; cam_done_cnt++; end
         disp_busy = 0;
      end
      prev_req = mem_req; prev_ack = mem_ack; prev_we = mem_we; prev_addr = mem_addr;
   endtask

   // one cycle: compare at the falling edge, then drive inputs just after the rising edge
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
      mem_ack = 0; mem_done = 0;
      if (!rst) begin
         rsp_busy = 0; rsp_wait = 0;
      end else if (!rsp_busy) begin
         if (mem_req) begin
            if (rsp_wait <= 0) begin
               mem_ack = 1; rsp_busy = 1;
               rsp_wait = fast ? 0 : int'($urandom_range(0, 4));
            end else rsp_wait--;
         end else if (stray_en && $urandom_range(0, 7) == 0) begin
            mem_done = 1;
         end
      end else if (!hold_done) begin
         if (rsp_wait <= 0) begin
            mem_done = 1; rsp_busy = 0;
            rsp_wait = fast ? 0 : int'($urandom_range(0, 3));
         end else rsp_wait--;
      end
      if (cam_req && cam_gnt_cnt != cam_mark) cam_req = 0;
      H_count = 11'($urandom_range(0, FETCH_START - 1));
      V_count = 11'($urandom_range(0, ENDFRAME));
   endtask

   task automatic trigger(input int v);
      step();
      H_count = 11'(FETCH_START);
      V_count = 11'(v);
      step();
   endtask

   task automatic start_cam(input logic [ADDR_W-1:0] a);
      cam_addr = a; cam_exp = a; cam_mark = cam_gnt_cnt; cam_req = 1;
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while ((disp_q.size() != 0 || disp_busy || cam_busy || cam_req) && n < 5000) begin
         step(); n++;
      end
      chk({name, "_drain_timeout"}, 32'(n < 5000), 32'h1);
      repeat (3) step();
   endtask

   task automatic wait_disp_busy(input string name);
      int n = 0;
      while (!disp_busy && n < 50) begin step(); n++; end
      chk({name, "_grant_timeout"}, 32'(n < 50), 32'h1);
   endtask

   initial begin
      int cd;
      // reset and quiet start
      repeat (3) step();
      rst = 1;
      repeat (5) step();
      chk("post_reset_lb_sel", 32'(lb_sel), 32'h0);
      chk("post_reset_mem_req", 32'(mem_req), 32'h0);

      // end-of-frame trigger: line 0 at address 0
      seen_q.delete();
      trigger(ENDFRAME);
      wait_drain("eof_line");
      chk("eof_count", 32'(seen_q.size()), 32'd50);
      chk("eof_first", 32'(seen_q[0]), 32'd0);
      chk("eof_last", 32'(seen_q[49]), 32'd784);
      chk("eof_lb_sel", 32'(lb_sel), 32'h1);
      chk("eof_underrun", 32'(underrun), 32'h0);

      // next line from 800
      seen_q.delete();
      trigger(0);
      wait_drain("line0");
      chk("line0_first", 32'(seen_q[0]), 32'd800);
      chk("line0_last", 32'(seen_q[49]), 32'd1584);
      chk("line0_lb_sel", 32'(lb_sel), 32'h0);

      // camera waits behind a pending display line
      seen_q.delete();
      cd = cam_done_cnt;
      trigger(1);
      start_cam(20'h40000);
      wait_drain("cam_prio");
      chk("cam_prio_reads_first", 32'(disp_before_cam), 32'd50);
      chk("cam_prio_addr", 32'(cam_last), 32'h40000);
      chk("cam_prio_done", 32'(cam_done_cnt), 32'(cd + 1));
      chk("cam_prio_first_read", 32'(seen_q[0]), 32'd1600);

      // trigger while the camera burst is in flight
      seen_q.delete();
      cd = cam_done_cnt;
      hold_done = 1;
      start_cam(20'h0ABCD);
      begin
         int n = 0;
         while (!cam_busy && n < 50) begin step(); n++; end
         chk("cam_busy_grant_timeout", 32'(n < 50), 32'h1);
      end
      repeat (2) step();
      trigger(2);
      repeat (3) step();
      chk("cam_busy_no_reads_yet", 32'(seen_q.size()), 32'd0);
      hold_done = 0;
      wait_drain("cam_busy");
      chk("cam_busy_done", 32'(cam_done_cnt), 32'(cd + 1));
      chk("cam_busy_reads", 32'(seen_q.size()), 32'd50);
      chk("cam_busy_first_read", 32'(seen_q[0]), 32'd2400);

      // burst stalled past the next trigger: underrun, stale done ignored
      seen_q.delete();
      hold_done = 1;
      trigger(3);
      wait_disp_busy("stall");
      repeat (300) step();
      chk("stall_underrun_before", 32'(underrun), 32'h0);
      trigger(4);
      chk("stall_underrun_after", 32'(underrun), 32'h1);
      hold_done = 0;
      wait_drain("stall");
      chk("stall_count", 32'(seen_q.size()), 32'd51);
      chk("stall_stale_addr", 32'(seen_q[0]), 32'd3200);
      chk("stall_reload_first", 32'(seen_q[1]), 32'd4000);
      chk("stall_reload_last", 32'(seen_q[50]), 32'd4784);

      // randomised traffic
      fast = 0;
      stray_en = 1;
      for (int it = 0; it < 10; it++) begin
         int v;
         if ($urandom_range(0, 3) == 0) v = ENDFRAME;
         else v = int'($urandom_range(0, V_ACTIVE - 2));
         if ($urandom_range(0, 1) == 1) start_cam(ADDR_W'($urandom));
         repeat ($urandom_range(0, 3)) step();
         trigger(v);
         if ($urandom_range(0, 1) == 1) trigger(int'($urandom_range(V_ACTIVE - 1, ENDFRAME - 1)));
         wait_drain("random");
      end
      stray_en = 0;
      fast = 1;

      // asynchronous reset in the middle of a display burst
      hold_done = 1;
      trigger(5);
      wait_disp_busy("rst_mid");
      repeat (2) step();
      #2 rst = 0;
      #1;
      chk("async_rst_mem_req", 32'(mem_req), 32'h0);
      chk("async_rst_mem_we", 32'(mem_we), 32'h0);
      chk("async_rst_mem_addr", 32'(mem_addr), 32'h0);
      chk("async_rst_underrun", 32'(underrun), 32'h0);
      chk("async_rst_flags", {28'b0, cam_gnt, cam_done, lb_sel, 1'b0}, 32'h0);
      hold_done = 0;
      repeat (3) step();
      rst = 1;
      seen_q.delete();
      cd = cam_done_cnt;
      repeat (100) step();
      chk("rst_quiet_reads", 32'(seen_q.size()), 32'd0);
      chk("rst_quiet_cam_done", 32'(cam_done_cnt), 32'(cd));
      trigger(10);
      wait_drain("after_rst");
      chk("after_rst_first", 32'(seen_q[0]), 32'd0);
      chk("after_rst_count", 32'(seen_q.size()), 32'd50);
      chk("after_rst_lb_sel", 32'(lb_sel), 32'h1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
